// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART bus port: FSM state encoding and
// fixed timing constants used by the strobe sequencer.
package uart_bus_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_LOW   = 3'd1,
      RD_DONE  = 3'd2,
      RD_RECOV = 3'd3,
      WR_LOW   = 3'd4,
      WR_HOLD  = 3'd5,
      WR_TBRE  = 3'd6,
      WR_TSRE  = 3'd7
   } state_t;

   localparam int SYNC_STAGES  = 2;
   localparam int RECOV_CYCLES = 2;
   localparam int TBRE_IGNORE  = 2;
   localparam int CNT_W        = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small register-based receive FIFO with wrap-around pointers; head is
// presented combinationally from registered state.
module uart_rx_fifo
   import uart_bus_pkg::*;
#(
   parameter int RX_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       empty,
   output logic       full
);

   localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

   logic [7:0]       r_mem [RX_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;

   // NOTE: storage is not reset; only pointers and count are, and the head is meaningless while empty.
   always_ff @(posedge CLK) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign empty = (r_count == '0);
   assign full  = (r_count == (PTR_W+1)'(RX_DEPTH));

endmodule

// File: rtl/uart_bus_port.sv
// UART chip front-end: turns the rdn/wrn/data_ready/tbre/tsre strobe protocol
// into valid/ready byte streams, arbitrating for the data bus shared with Ram1.
module uart_bus_port
   import uart_bus_pkg::*;
#(
   parameter int RD_PULSE = 2,
   parameter int WR_PULSE = 2,
   parameter int RX_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       data_ready,
   input  logic       tbre,
   input  logic       tsre,
   output logic       rdn,
   output logic       wrn,
   output logic       bus_req,
   input  logic       bus_gnt,
   input  logic [7:0] bus_data_in,
   output logic [7:0] bus_data_out,
   output logic       bus_data_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy
);

   logic [SYNC_STAGES-1:0] r_drdy_sync, r_tbre_sync, r_tsre_sync;
   state_t                 r_state, w_next_state;
   logic [CNT_W-1:0]       r_cnt, w_next_cnt;
   logic                   r_tx_full;
   logic [7:0]             r_tx_hold;
   logic [7:0]             r_rx_byte;
   logic                   r_rdn, r_wrn, r_oe;
   logic [7:0]             r_bus_data_out;
   logic                   w_drdy_s, w_tbre_s, w_tsre_s;
   logic                   w_rd_wanted, w_wr_wanted, w_bus_req;
   logic                   w_fifo_empty, w_fifo_full, w_drive_next, w_tx_clear;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_drdy_sync <= '0;
         r_tbre_sync <= '0;
         r_tsre_sync <= '0;
      end else begin
         r_drdy_sync <= {r_drdy_sync[SYNC_STAGES-2:0], data_ready};
         r_tbre_sync <= {r_tbre_sync[SYNC_STAGES-2:0], tbre};
         r_tsre_sync <= {r_tsre_sync[SYNC_STAGES-2:0], tsre};
      end
   end

   assign w_drdy_s    = r_drdy_sync[SYNC_STAGES-1];
   assign w_tbre_s    = r_tbre_sync[SYNC_STAGES-1];
   assign w_tsre_s    = r_tsre_sync[SYNC_STAGES-1];
   assign w_rd_wanted = w_drdy_s && !w_fifo_full;
   assign w_wr_wanted = r_tx_full;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_bus_req    = 1'b0;
      case (r_state)
         IDLE: begin
            w_bus_req = w_rd_wanted || w_wr_wanted;
            if (bus_gnt && w_rd_wanted) begin
               w_next_state = RD_LOW;
               w_next_cnt   = CNT_W'(RD_PULSE - 1);
            end else if (bus_gnt && w_wr_wanted) begin
               w_next_state = WR_LOW;
               w_next_cnt   = CNT_W'(WR_PULSE - 1);
            end
         end
         RD_LOW: begin
            w_bus_req = 1'b1;
            if (r_cnt == '0) w_next_state = RD_DONE;
            else             w_next_cnt   = r_cnt - CNT_W'(1);
         end
         RD_DONE: begin
            w_next_state = RD_RECOV;
            w_next_cnt   = CNT_W'(RECOV_CYCLES - 1);
         end
         RD_RECOV: begin
            if (r_cnt == '0) w_next_state = IDLE;
            else             w_next_cnt   = r_cnt - CNT_W'(1);
         end
         WR_LOW: begin
            w_bus_req = 1'b1;
            if (r_cnt == '0) w_next_state = WR_HOLD;
            else             w_next_cnt   = r_cnt - CNT_W'(1);
         end
         WR_HOLD: begin
            w_bus_req    = 1'b1;
            w_next_state = WR_TBRE;
            w_next_cnt   = CNT_W'(TBRE_IGNORE);
         end
         // tbre_s may still show the pre-write value for a couple of cycles.
         WR_TBRE: begin
            if (r_cnt != '0)   w_next_cnt   = r_cnt - CNT_W'(1);
            else if (w_tbre_s) w_next_state = WR_TSRE;
         end
         WR_TSRE: begin
            if (w_tsre_s) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign w_drive_next = (w_next_state == WR_LOW) || (w_next_state == WR_HOLD);
   assign w_tx_clear   = (r_state == WR_TSRE) && (w_next_state == IDLE);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_rdn          <= 1'b1;
         r_wrn          <= 1'b1;
         r_oe           <= 1'b0;
         r_bus_data_out <= '0;
         r_rx_byte      <= '0;
         r_tx_full      <= 1'b0;
         r_tx_hold      <= '0;
      end else begin
         r_state        <= w_next_state;
         r_cnt          <= w_next_cnt;
         r_rdn          <= (w_next_state != RD_LOW);
         r_wrn          <= (w_next_state != WR_LOW);
         r_oe           <= w_drive_next;
         r_bus_data_out <= w_drive_next ? r_tx_hold : 8'h00;
         if (r_state == RD_LOW && r_cnt == '0) r_rx_byte <= bus_data_in;
         if (w_tx_clear) begin
            r_tx_full <= 1'b0;
         end else if (tx_valid && !r_tx_full) begin
            r_tx_full <= 1'b1;
            r_tx_hold <= tx_data;
         end
      end
   end

   uart_rx_fifo #(.RX_DEPTH(RX_DEPTH)) u_rx_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (r_state == RD_DONE),
      .push_data (r_rx_byte),
      .pop       (rx_ready),
      .head      (rx_data),
      .empty     (w_fifo_empty),
      .full      (w_fifo_full)
   );

   assign rdn          = r_rdn;
   assign wrn          = r_wrn;
   assign bus_req      = w_bus_req;
   assign bus_data_out = r_bus_data_out;
   assign bus_data_oe  = r_oe;
   assign rx_valid     = !w_fifo_empty;
   assign tx_ready     = !r_tx_full;
   assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_bus_port.sv
// Self-checking bench for uart_bus_port: a behavioural UART chip, bus arbiter,
// producer and consumer, with byte-stream scoreboards and strobe-timing checks.
module tb_uart_bus_port;

   localparam int RD_PULSE = 2;
   localparam int WR_PULSE = 2;
   localparam int RX_DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RST;
   logic       data_ready, tbre, tsre, rdn, wrn, bus_req, bus_gnt;
   logic [7:0] bus_data_in, bus_data_out, rx_data, tx_data;
   logic       bus_data_oe, rx_valid, rx_ready, tx_valid, tx_ready, busy;

   uart_bus_port #(.RD_PULSE(RD_PULSE), .WR_PULSE(WR_PULSE), .RX_DEPTH(RX_DEPTH)) dut (
      .CLK(CLK), .RST(RST), .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
      .rdn(rdn), .wrn(wrn), .bus_req(bus_req), .bus_gnt(bus_gnt),
      .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural world model state.
   logic [7:0] chip_q[$];      // bytes waiting inside the UART chip
   logic [7:0] exp_rx_q[$];    // bytes the consumer must see, in order
   logic [7:0] exp_tx_q[$];    // bytes accepted by the DUT, in order
   logic [7:0] tx_src_q[$];    // bytes the producer still has to offer
   bit    rd_blocked, was_write, post_hold, tx_rand;
   bit    prev_rdn, prev_wrn, prev_busy;
   int    rd_low_cnt, wr_low_cnt, reads_done, writes_done;
   int    tbre_cnt, tsre_cnt, tbre_dly, tsre_dly, cyc, tsre_rise_cyc;
   int    gnt_mode, rx_policy;
   string op_log;

   task automatic model_reset();
      chip_q.delete(); exp_rx_q.delete(); exp_tx_q.delete(); tx_src_q.delete();
      rd_blocked = 0; was_write = 0; post_hold = 0;
      prev_rdn = 1; prev_wrn = 1; prev_busy = 0;
      rd_low_cnt = 0; wr_low_cnt = 0; tbre_cnt = 0; tsre_cnt = 0;
      data_ready = 0; tbre = 1; tsre = 1; bus_data_in = 8'h00;
      tx_valid = 0; tx_data = 8'h00; rx_ready = 0; bus_gnt = 0;
   endtask

   task automatic inject(input logic [7:0] b);
      chip_q.push_back(b);
      exp_rx_q.push_back(b);
   endtask

   task automatic step();
      @(negedge CLK);
      cyc++;
      check("rd_wr_exclusive", 32'(rdn | wrn), 1);
      // UART transmitter timing: tbre, then tsre, some cycles after a write.
      if (tbre_cnt > 0) begin
         tbre_cnt--;
         if (tbre_cnt == 0) begin tbre = 1; tsre_cnt = tsre_dly; end
      end else if (tsre_cnt > 0) begin
         tsre_cnt--;
         if (tsre_cnt == 0) begin tsre = 1; tsre_rise_cyc = cyc; end
      end
      // Read strobe monitor and chip read side.
      if (!rdn) begin
         if (prev_rdn) begin
            op_log = {op_log, "R"};
            check("rd_gnt", 32'(bus_gnt), 1);
            check("rd_req", 32'(bus_req), 1);
         end
         rd_low_cnt++;
         rd_blocked = 1;
      end else if (!prev_rdn) begin
         check("rd_pulse", rd_low_cnt, RD_PULSE);
         rd_low_cnt = 0;
         rd_blocked = 0;
         if (chip_q.size() > 0) void'(chip_q.pop_front());
         reads_done++;
      end
      // Write strobe monitor.
      if (post_hold) begin
         check("wr_oe_off", 32'(bus_data_oe), 0);
         check("wr_release_req", 32'(bus_req), 0);
         post_hold = 0;
      end
      if (!wrn) begin
         if (prev_wrn) begin
            op_log = {op_log, "W"};
            check("wr_gnt", 32'(bus_gnt), 1);
            was_write = 1;
            tbre = 0; tsre = 0; tbre_cnt = tbre_dly; tsre_cnt = 0;
         end
         wr_low_cnt++;
         check("wr_oe", 32'(bus_data_oe), 1);
         check("wr_byte_known", 32'(exp_tx_q.size() > 0), 1);
         if (exp_tx_q.size() > 0) check("wr_data", bus_data_out, exp_tx_q[0]);
      end else if (!prev_wrn) begin
         check("wr_pulse", wr_low_cnt, WR_PULSE);
         check("wr_hold_oe", 32'(bus_data_oe), 1);
         if (exp_tx_q.size() > 0) check("wr_hold_data", bus_data_out, exp_tx_q.pop_front());
         wr_low_cnt = 0;
         post_hold = 1;
         writes_done++;
      end
      if (was_write && busy) check("tx_ready_held", 32'(tx_ready), 0);
      if (prev_busy && !busy && was_write) begin
         check("tsre_to_idle", cyc - tsre_rise_cyc, 3);
         check("tx_ready_back", 32'(tx_ready), 1);
         was_write = 0;
      end
      data_ready  = (chip_q.size() > 0) && !rd_blocked;
      bus_data_in = (chip_q.size() > 0) ? chip_q[0] : 8'h00;
      // Arbiter: holds the grant while the DUT keeps requesting.
      case (gnt_mode)
         0:       bus_gnt = 1'b0;
         1:       bus_gnt = 1'b1;
         default: bus_gnt = (bus_gnt && bus_req) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      // Consumer: a pop happens at the coming edge if rx_valid && rx_ready.
      case (rx_policy)
         0:       rx_ready = 1'b0;
         1:       rx_ready = 1'b1;
         default: rx_ready = 1'($urandom_range(0, 1));
      endcase
      if (rx_valid && rx_ready) begin
         check("rx_byte_expected", 32'(exp_rx_q.size() > 0), 1);
         if (exp_rx_q.size() > 0) check("rx_data", rx_data, exp_rx_q.pop_front());
      end
      // Producer: acceptance happens at the coming edge if tx_valid && tx_ready.
      tx_valid = (tx_src_q.size() > 0) && (!tx_rand || ($urandom_range(0, 2) != 0));
      tx_data  = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
      if (tx_valid && tx_ready) begin
         exp_tx_q.push_back(tx_data);
         void'(tx_src_q.pop_front());
      end
      prev_rdn = rdn; prev_wrn = wrn; prev_busy = busy;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n_inj, n_tx, budget;
      bit seen, done;
      cyc = 0; reads_done = 0; writes_done = 0; op_log = "";
      gnt_mode = 1; rx_policy = 0; tx_rand = 0; tbre_dly = 5; tsre_dly = 3; tsre_rise_cyc = 0;
      RST = 1'b0;
      model_reset();
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("rst_rdn", 32'(rdn), 1);
      check("rst_wrn", 32'(wrn), 1);
      check("rst_bus_req", 32'(bus_req), 0);
      check("rst_oe", 32'(bus_data_oe), 0);
      check("rst_bus_data_out", bus_data_out, 8'h00);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_tx_ready", 32'(tx_ready), 1);
      check("rst_busy", 32'(busy), 0);

      // Single receive.
      inject(8'h5A);
      budget = 40;
      do begin step(); budget--; end while (!rx_valid && budget > 0);
      check("rx1_valid", 32'(rx_valid), 1);
      check("rx1_data", rx_data, 8'h5A);
      steps(20);
      check("rx1_single_read", reads_done, 1);
      rx_policy = 1; step(); rx_policy = 0; step();
      check("rx1_popped", 32'(rx_valid), 0);

      // FIFO full: five bytes, only four reads until one is popped.
      base = reads_done;
      for (int i = 1; i <= 5; i++) inject(8'(i));
      steps(60);
      check("full_reads", reads_done - base, RX_DEPTH);
      seen = 0;
      for (int i = 0; i < 20; i++) begin step(); seen |= bus_req; end
      check("full_req_quiet", 32'(seen), 0);
      check("full_busy", 32'(busy), 0);
      rx_policy = 1; step(); rx_policy = 0;
      steps(20);
      check("full_fifth_read", reads_done - base, 5);
      check("full_head", rx_data, 8'h02);
      rx_policy = 1; steps(10); rx_policy = 0;
      check("full_drained", 32'(exp_rx_q.size()), 0);
      check("full_empty", 32'(rx_valid), 0);

      // Transmit.
      base = writes_done;
      tx_src_q.push_back(8'hA3);
      steps(2);
      check("tx_ready_low", 32'(tx_ready), 0);
      budget = 80;
      do begin step(); budget--; end while ((writes_done == base || busy) && budget > 0);
      check("tx_done", writes_done - base, 1);
      check("tx_idle", 32'(busy), 0);
      check("tx_ready_idle", 32'(tx_ready), 1);

      // Bus grant withheld.
      gnt_mode = 0;
      inject(8'h3C);
      seen = 0;
      for (int i = 0; i < 10; i++) begin step(); seen |= !rdn; end
      check("nogrant_rdn", 32'(seen), 0);
      check("nogrant_req", 32'(bus_req), 1);
      gnt_mode = 1;
      step();
      step();
      check("grant_rdn_next", 32'(rdn), 0);
      steps(10);
      rx_policy = 1; steps(5); rx_policy = 0;
      check("grant_drained", 32'(exp_rx_q.size()), 0);

      // Read and write wanted together: the read goes first.
      gnt_mode = 0; op_log = ""; base = writes_done;
      inject(8'hC7);
      tx_src_q.push_back(8'h96);
      steps(8);
      check("both_req", 32'(bus_req), 1);
      gnt_mode = 1; rx_policy = 1;
      budget = 100;
      do begin step(); budget--; end while ((writes_done == base || busy) && budget > 0);
      check("both_order", 32'(op_log == "RW"), 1);
      rx_policy = 0;

      // Reset during the write strobe.
      inject(8'h11);
      budget = 40;
      do begin step(); budget--; end while (!rx_valid && budget > 0);
      tx_src_q.push_back(8'h77);
      budget = 40;
      do begin step(); budget--; end while (wrn && budget > 0);
      check("midwr_wrn_low", 32'(wrn), 0);
      #2 RST = 1'b0;
      #1;
      check("midwr_rst_wrn", 32'(wrn), 1);
      check("midwr_rst_oe", 32'(bus_data_oe), 0);
      check("midwr_rst_tx_ready", 32'(tx_ready), 1);
      check("midwr_rst_rx_valid", 32'(rx_valid), 0);
      check("midwr_rst_busy", 32'(busy), 0);
      model_reset();
      @(negedge CLK);
      RST = 1'b1;

      // Randomised traffic with a random arbiter and random chip timing.
      gnt_mode = 2; rx_policy = 2; tx_rand = 1;
      base = reads_done; n_inj = 0; n_tx = 0;
      for (int i = 0; i < 800; i++) begin
         tbre_dly = $urandom_range(4, 8);
         tsre_dly = $urandom_range(1, 4);
         if ($urandom_range(0, 9) == 0 && n_inj < 40) begin inject(8'($urandom)); n_inj++; end
         if ($urandom_range(0, 9) == 0 && n_tx < 40) begin tx_src_q.push_back(8'($urandom)); n_tx++; end
         step();
      end
      budget = 3000;
      do begin
         step();
         budget--;
         done = (chip_q.size() == 0) && (exp_rx_q.size() == 0) && (exp_tx_q.size() == 0)
                && (tx_src_q.size() == 0) && !busy && !rx_valid;
      end while (!done && budget > 0);
      check("rand_drained", 32'(done), 1);
      check("rand_reads", reads_done - base, n_inj);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_bus_port.md
Name: uart_bus_port

Overview:
- Front-end between the board UART chip (rdn/wrn/data_ready/tbre/tsre handshake) and the serial controller stage that consumes received bytes and supplies bytes to send.
- Converts the raw UART strobe protocol into clean valid/ready byte streams.
- Buffers received bytes in a small FIFO.
- Requests the data bus shared with Ram1 before driving or sampling it.

Parameters:
- RD_PULSE, 2, cycles rdn is held low per read (min 2).
- WR_PULSE, 2, cycles wrn is held low per write (min 1).
- RX_DEPTH, 4, receive FIFO entries (power of 2, min 2).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset; asynchronous, active-low.
- data_ready  in  1  UART byte-available flag (asynchronous).
- tbre  in  1  UART transmit buffer empty (asynchronous).
- tsre  in  1  UART transmit shift register empty (asynchronous).
- rdn  out  1  UART read strobe, active-low.
- wrn  out  1  UART write strobe, active-low.
- bus_req  out  1  request for the shared data bus.
- bus_gnt  in  1  bus granted to this block.
- bus_data_in  in  8  low byte of the shared data bus, as read.
- bus_data_out  out  8  byte to drive onto the bus.
- bus_data_oe  out  1  when 1, the parent drives bus_data_out onto the bus; otherwise the bus is high-Z.
- rx_data  out  8  head byte of the receive FIFO.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  transmit request.
- tx_ready  out  1  transmit holding register empty; byte accepted when tx_valid && tx_ready.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (RST low, asynchronous, any state including mid-strobe): rdn=1, wrn=1, bus_req=0, bus_data_oe=0, bus_data_out=0, rx_valid=0, tx_ready=1, busy=0. FIFO is cleared, the tx holding register is discarded, and the synchronisers clear to 0.
- Synchronisers: data_ready, tbre and tsre each pass through a 2-flop synchroniser, giving drdy_s, tbre_s and tsre_s. Only the synchronised copies are used.
- Tx holding register (1 entry): loads on tx_valid && tx_ready, after which tx_ready=0. It is cleared, and tx_ready returns to 1, on the cycle the FSM leaves WR_TSRE.
- Start conditions, evaluated in IDLE:
  - Read wanted: drdy_s=1 && FIFO not full.
  - Write wanted: holding register full.
  - Read has priority over write.
  - bus_req=1 whenever a start is wanted.
  - An operation starts only on a cycle with bus_gnt=1.
- FSM states: IDLE, RD_LOW, RD_DONE, RD_RECOV, WR_LOW, WR_HOLD, WR_TBRE, WR_TSRE.
  - IDLE -> RD_LOW when read wanted && bus_gnt.
  - IDLE -> WR_LOW when write wanted && no read wanted && bus_gnt.
  - RD_LOW: rdn=0, bus_req=1, for exactly RD_PULSE cycles. bus_data_in is registered on the edge that leaves RD_LOW.
  - RD_DONE (1 cycle): rdn=1, the captured byte is pushed into the FIFO, bus_req=0.
  - RD_RECOV (2 cycles): lets drdy_s settle so the same byte is not read twice; then -> IDLE.
  - WR_LOW: wrn=0, bus_data_oe=1, bus_data_out=holding byte, bus_req=1, for WR_PULSE cycles.
  - WR_HOLD (1 cycle): wrn=1, bus_data_oe=1, data still driven (hold time); bus_req=1.
  - WR_TBRE: bus released (bus_req=0, bus_data_oe=0). tbre_s is ignored for the first 2 cycles; then -> WR_TSRE when tbre_s=1.
  - WR_TSRE: -> IDLE when tsre_s=1.
- rdn and wrn are registered outputs and are never low in the same cycle.
- FIFO: rx_data/rx_valid reflect the head combinationally from registered state.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - A push never happens while full, because reads start only when the FIFO is not full.
  - Pointers wrap modulo RX_DEPTH.
- Loss of bus_gnt mid-operation is not legal; the arbiter must hold the grant while bus_req=1. The block does not abort.
- The block has no timeout: WR_TBRE/WR_TSRE wait indefinitely.

Decomposition:
- Shared package uart_bus_pkg:
  - FSM state enum (3-bit encoding).
  - Constants SYNC_STAGES=2 and RECOV_CYCLES=2.
- Sub-module uart_rx_fifo (parameter RX_DEPTH):
  - Ports: CLK, RST, push, push_data, pop, head, empty, full.
  - Register-based storage with wrap-around pointers.
- The top level holds the synchronisers, the FSM, the tx holding register and the pulse counters.

Test Plan:
- Single receive: RD_PULSE=2, hold bus_gnt=1, raise data_ready with bus byte 0x5A, drop data_ready once rdn falls -> rdn low for exactly 2 cycles; rx_valid=1 with rx_data=0x5A; no second read.
- FIFO full: keep rx_ready=0 and deliver 5 bytes 0x01..0x05 -> only 4 reads occur and bus_req stays 0 while full. Then pop one -> 0x05 is read; pop order is 0x01..0x05.
- Transmit: tx_data=0xA3, tx_valid=1 -> tx_ready=0; wrn low for WR_PULSE cycles with bus_data_oe=1 and bus_data_out=0xA3; oe held one extra cycle. tbre rising 5 cycles later, then tsre 3 cycles later -> IDLE with tx_ready=1.
- Simultaneous: data_ready high and tx byte pending in the same cycle -> read completes first, then the write; rdn and wrn never low together.
- Bus grant withheld: bus_gnt=0 for 10 cycles with data_ready high -> bus_req=1, rdn stays 1. Grant -> read starts the next cycle.
- Reset mid-write: assert RST during WR_LOW -> wrn=1 and bus_data_oe=0 immediately (asynchronous), tx_ready=1, FIFO empty.
